lzss_decoder: RTL

Downstream stage of the LZSS encoder. Consumes the encoder's 11-bit codeword stream and its finish indication, and rebuilds the original byte stream. It keeps a mirror of the encoder's 256-byte sliding dictionary and emits one byte per cycle on a valid/ready output. It is used for on-chip loopback checking and for the decompression path.

---
 rtl/lzss_pkg.sv | 29 ++
 rtl/lzss_dict_shift.sv | 53 +++++
 rtl/lzss_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lzss_pkg.sv
// -----------------------------------------------------------------------------
// lzss_pkg
// Shared definitions for the LZSS encoder/decoder pair: codeword field
// positions, match-length bias, decoder FSM states and dictionary defaults.
// No ports.
// -----------------------------------------------------------------------------
package lzss_pkg;

    // Dictionary geometry; must match the encoder.
    localparam int DEF_DICT_DEPTH = 256;
    localparam int DEF_SYM_W      = 8;

    // Codeword layout: {flag, pos/literal[7:0], len_code[1:0]}.
    localparam int CW_W     = 11;
    localparam int FLAG_BIT = 10;
    localparam int POS_MSB  = 9;
    localparam int POS_LSB  = 2;
    localparam int LEN_MSB  = 1;

    // Length code 0 encodes the shortest useful match.
    localparam int LEN_BASE = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lzss_dict_shift.sv
// -----------------------------------------------------------------------------
// lzss_dict_shift
// Sliding dictionary: DEPTH x SYM_W shift register, newest byte at index 0.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   shift_en, din   push din into entry 0, oldest entry falls off the end
//   rd_idx, rd_data combinational read port
//   fill            number of valid entries, saturates at DEPTH
// -----------------------------------------------------------------------------
module lzss_dict_shift
    import lzss_pkg::*;
#(
    parameter int DEPTH = DEF_DICT_DEPTH,
    parameter int SYM_W = DEF_SYM_W,
    localparam int IW   = $clog2(DEPTH),
    localparam int FW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [SYM_W-1:0] din,
    input  logic [IW-1:0]    rd_idx,
    output logic [SYM_W-1:0] rd_data,
    output logic [FW-1:0]    fill
);

    logic [SYM_W-1:0] mem [DEPTH];

    // NOTE: this storage is reset on purpose: a match that points at a
    // never-written entry must read back 0, so a plain RAM without reset
    // would not behave correctly here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            fill <= '0;
        end else if (shift_en) begin
            // NOTE: non-blocking assignments make every entry take its
            // neighbour's old value in parallel, which is what a shift needs.
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
            if (fill != FW'(DEPTH)) begin
                fill <= fill + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/lzss_decoder.sv
// -----------------------------------------------------------------------------
// lzss_decoder
// Rebuilds the byte stream from the LZSS encoder's 11-bit codewords.
// Literals emit one byte; matches copy len bytes out of the mirrored
// dictionary, one byte per cycle.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cw_valid/cw_data/cw_ready   codeword input handshake
//   enc_finish            encoder finished (level or pulse, latched)
//   out_data/out_valid/out_ready  decoded byte output handshake
//   dec_num               bytes accepted downstream (wraps)
//   done                  stream fully decoded and drained (sticky)
//   err                   match referenced outside the filled dictionary (sticky)
// -----------------------------------------------------------------------------
module lzss_decoder
    import lzss_pkg::*;
#(
    parameter int DICT_DEPTH = DEF_DICT_DEPTH,
    parameter int SYM_W      = DEF_SYM_W,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cw_valid,
    input  logic [CW_W-1:0]  cw_data,
    output logic             cw_ready,
    input  logic             enc_finish,
    output logic [SYM_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] dec_num,
    output logic             done,
    output logic             err
);

    localparam int IW = $clog2(DICT_DEPTH);
    localparam int FW = $clog2(DICT_DEPTH + 1);

    state_t           state;
    logic [IW:0]      src;       // one extra bit so out-of-range positions are visible
    logic [2:0]       rem;
    logic             fin_q;
    logic             run_q;     // holds cw_ready low until the first clock after reset

    logic             adv;
    logic             accept;
    logic             is_match;
    logic [2:0]       len;
    logic [IW:0]      match_src;
    logic             go_done;
    logic             shift_en;
    logic [SYM_W-1:0] shift_din;
    logic [SYM_W-1:0] rd_data;
    logic [SYM_W-1:0] copy_byte;
    logic [FW-1:0]    fill;

    // NOTE: every signal gets a value at the top of always_comb so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        adv       = !out_valid || out_ready;
        cw_ready  = run_q && (state == S_IDLE) && adv && !done;
        accept    = cw_valid && cw_ready;
        is_match  = cw_data[FLAG_BIT];
        len       = {1'b0, cw_data[LEN_MSB:0]} + 3'(LEN_BASE);
        // Bytes are read oldest-first, so the copy starts at the far end.
        match_src = (IW+1)'(cw_data[POS_MSB:POS_LSB]) + (IW+1)'(len) - (IW+1)'(1);
        // Positions beyond the dictionary have no storage and read as 0.
        copy_byte = src[IW] ? '0 : rd_data;
        shift_en  = (accept && !is_match) || ((state == S_COPY) && adv);
        shift_din = (state == S_COPY) ? copy_byte : cw_data[POS_MSB:POS_LSB];
        go_done   = fin_q && (state == S_IDLE) && !accept && adv && run_q;
    end

    lzss_dict_shift #(
        .DEPTH (DICT_DEPTH),
        .SYM_W (SYM_W)
    ) u_dict (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (shift_din),
        .rd_idx   (src[IW-1:0]),
        .rd_data  (rd_data),
        .fill     (fill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            src       <= '0;
            rem       <= '0;
            fin_q     <= 1'b0;
            run_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            dec_num   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            run_q <= 1'b1;
            fin_q <= fin_q | enc_finish;

            if (out_valid && out_ready) begin
                dec_num <= dec_num + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (accept && !is_match) begin
                        out_data  <= cw_data[POS_MSB:POS_LSB];
                        out_valid <= 1'b1;
                    end else if (accept) begin
                        src       <= match_src;
                        rem       <= len;
                        out_valid <= 1'b0;
                        state     <= S_COPY;
                        if (match_src[IW] || (match_src >= fill)) begin
                            err <= 1'b1;
                        end
                    end else if (adv) begin
                        out_valid <= 1'b0;
                        if (go_done) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                // src stays put: each shift slides the next source byte into it.
                S_COPY: begin
                    if (adv) begin
                        out_data  <= copy_byte;
                        out_valid <= 1'b1;
                        rem       <= rem - 1'b1;
                        if (rem == 3'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_DONE: begin
                    if (adv) begin
                        out_valid <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
